regfile_swap_sequencer: RTL and testbench
=========================================

# regfile_swap_sequencer

Sequences a hardware-scheduler context swap into the pipelined core's register file. On a swap request it waits for the pipeline to drain, then copies architectural registers x1..x31 from the out-of-order core's physical register file (via the retirement RAT mapping) into the pipeline regfile. Copying uses the regfile's single write port, one register per cycle. The block owns that write port and arbitrates it between normal writeback and swap traffic. It sits between the writeback stage, the hardware scheduler and the decode-stage regfile.

## Interface
- NUM_REGS, 64, physical register count of the OOO core; index width PW = $clog2(NUM_REGS)

- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low
- swap_req  in  1  scheduler request; level, held high until swap_done seen
- pipe_empty  in  1  no valid instruction in ID/EX/MEM/WB
- rrf_arch_to_physical  in  32 x PW  arch-to-physical map
- ooo_data  in  NUM_REGS x 32  OOO physical register values
- wb_we  in  1  writeback write enable (already qualified by valid)
- wb_rd_s  in  5  writeback destination
- wb_rd_v  in  32  writeback data
- regf_we  out  1  regfile write enable
- regf_rd_s  out  5  regfile write index
- regf_rd_v  out  32  regfile write data
- swap_busy  out  1  stall fetch and decode
- swap_done  out  1  one-cycle completion pulse
- swap_checksum  out  32  only with SWAP_CHECKSUM_EN

## Operation
- States: IDLE, DRAIN, COPY, FLUSH, DONE, HOLD.
- IDLE: passes writeback through to the write port. Moves to DRAIN when swap_req=1.
- DRAIN: swap_busy=1; writeback still passes through. Moves to COPY when pipe_empty=1 and wb_we=0 in the same cycle.
- COPY uses a 5-bit index counter idx, starting at 1.
  - Each cycle, with the port free: capture ooo_data[rrf_arch_to_physical[idx]] and idx into stage register {sv, sv_idx, sv_valid}.
  - The previously captured entry is written out through the port.
  - idx increments by 1.
  - After capturing idx=31, go to FLUSH.
- FLUSH: write the last captured entry (x31), then go to DONE.
- DONE: swap_done=1 for exactly one cycle; swap_busy stays 1. Then go to HOLD.
- HOLD: swap_busy=0. Return to IDLE once swap_req=0, so a level request cannot trigger a second swap.
- Arbitration in COPY/FLUSH: writeback has priority.
  - If wb_we=1, the port carries the writeback.
  - idx, the stage register and the state all hold.
  - No swap value is lost or duplicated.
- Writes with index 0 are never issued. This covers wb_rd_s=0, where regf_we is forced to 0.
- swap_req dropping during DRAIN/COPY/FLUSH has no effect; the swap completes.

## Timing
- Reset values: state=IDLE, idx=1, sv_valid=0, regf_we=0, regf_rd_s=0, regf_rd_v=0, swap_busy=0, swap_done=0, swap_checksum=0.
- Reset asserted mid-swap aborts the swap at the next edge with all outputs as above. The regfile is left partially written.
- Write port outputs are combinational from state, stage register and wb inputs. The copy path itself is registered.
- Uncontended swap latency: DRAIN exit to swap_done pulse is 33 cycles (31 COPY, 1 FLUSH, 1 DONE). Each writeback collision adds 1 cycle.
- x1 is written in the cycle after the first COPY cycle. xN is written in the cycle after idx=N is captured.
- swap_busy is high from the cycle after swap_req is seen in IDLE through the DONE cycle inclusive.

## Configuration
- SWAP_CHECKSUM_EN defined:
  - swap_checksum exists.
  - It clears on entry to COPY and XOR-accumulates every swap value written to the port.
  - It is stable from DONE until the next COPY entry.
- SWAP_CHECKSUM_EN undefined: the port and accumulator are absent; behaviour is otherwise identical.

## Structure
- Shared package rv32i_types gets:
  - swap_state_t enum for the FSM.
  - the NUM_REGS constant.
- One sub-module, swap_write_arbiter: combinational 2-input priority mux for the write port (writeback over swap), with the x0 suppression. The FSM and counter stay in the top module.

## Test plan
- Reset low for 2 cycles mid-COPY at idx=10 -> next cycle state IDLE, swap_busy=0, regf_we=0. A new swap_req restarts copying from x1.
- Identity map with ooo_data[i]=i*0x100 -> x1..x31 written with 0x100..0x1F00 on consecutive cycles; swap_done 33 cycles after DRAIN exit.
- Permuted map with rrf_arch_to_physical[5]=40 and ooo_data[40]=0xDEADBEEF -> write x5=0xDEADBEEF.
- pipe_empty=0 for 4 cycles after swap_req -> swap_busy=1, no swap writes; a pending wb_we x7=0x55 passes through.
- wb_we=1 with x3=0xAA during COPY at idx=12 -> port writes x3=0xAA that cycle. The next cycle writes the held x11, and completion is delayed by 1 cycle.
- With SWAP_CHECKSUM_EN and ooo_data[i]=i under the identity map -> swap_checksum=0 (XOR of 1..31). swap_req held high after done -> no second swap until it drops.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared core types: register-file geometry and the context-swap FSM states.
package rv32i_types;

  // Physical register count of the out-of-order core.
  localparam int NUM_REGS  = 64;
  // Architectural registers x0..x31.
  localparam int ARCH_REGS = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_COPY  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4,
    S_HOLD  = 3'd5
  } swap_state_t;

endpackage

// File: rtl/swap_write_arbiter.sv
// Fixed-priority mux for the pipeline regfile write port.
// Writeback always wins over swap traffic. A write to x0 is never issued:
// the enable is dropped, and index and data are driven to zero.
module swap_write_arbiter (
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_rd_s,
  input  logic [31:0] i_wb_rd_v,
  input  logic        i_sw_we,
  input  logic [4:0]  i_sw_rd_s,
  input  logic [31:0] i_sw_rd_v,
  output logic        o_we,
  output logic [4:0]  o_rd_s,
  output logic [31:0] o_rd_v,
  output logic        o_sw_grant
);

  // Select writeback first, then the staged swap entry; suppress x0 writes.
  always_comb begin
    o_we       = 1'b0;
    o_rd_s     = 5'd0;
    o_rd_v     = 32'd0;
    o_sw_grant = 1'b0;
    if (i_wb_we) begin
      if (i_wb_rd_s != 5'd0) begin
        o_we   = 1'b1;
        o_rd_s = i_wb_rd_s;
        o_rd_v = i_wb_rd_v;
      end
    end else if (i_sw_we) begin
      o_sw_grant = 1'b1;
      if (i_sw_rd_s != 5'd0) begin
        o_we   = 1'b1;
        o_rd_s = i_sw_rd_s;
        o_rd_v = i_sw_rd_v;
      end
    end
  end

endmodule

// File: rtl/regfile_swap_sequencer.sv
// Context-swap sequencer for the pipeline register file.
// On swap_req it waits for the pipeline to drain, then copies x1..x31 from
// the OOO physical register file (through the retirement RAT) into the
// pipeline regfile, one register per cycle, through a single write port
// shared with writeback (writeback has priority).
//
// Handshake: swap_req is a level request, held until swap_done is seen.
// swap_busy is high from the cycle after the request is taken through the
// DONE cycle; swap_done pulses once. The FSM stays in HOLD until swap_req
// drops, so a held level cannot start a second swap.
//
// Optional feature macro: SWAP_CHECKSUM_EN adds the swap_checksum output,
// an XOR of every swap value written through the port during the last swap.
module regfile_swap_sequencer #(
  parameter  int NUM_REGS = rv32i_types::NUM_REGS,
  localparam int PW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     swap_req,
  input  logic                     pipe_empty,
  input  logic [PW-1:0]            rrf_arch_to_physical [32],
  input  logic [31:0]              ooo_data [NUM_REGS],
  input  logic                     wb_we,
  input  logic [4:0]               wb_rd_s,
  input  logic [31:0]              wb_rd_v,
  output logic                     regf_we,
  output logic [4:0]               regf_rd_s,
  output logic [31:0]              regf_rd_v,
  output logic                     swap_busy,
  output logic                     swap_done,
`ifdef SWAP_CHECKSUM_EN
  output logic [31:0]              swap_checksum,
`endif
  output rv32i_types::swap_state_t dbg_state
);

  rv32i_types::swap_state_t r_state;
  logic [4:0]  r_idx;
  logic [31:0] r_sv;
  logic [4:0]  r_sv_idx;
  logic        r_sv_valid;
  logic        r_swap_busy;
  logic        r_swap_done;

  logic [31:0] w_lookup;
  logic        w_port_free;
  logic        w_copy_start;
  logic        w_sw_we;
  logic        w_sw_grant;

  // Physical value of the architectural register currently addressed by idx.
  assign w_lookup     = ooo_data[rrf_arch_to_physical[r_idx]];
  // The swap path only advances in cycles writeback leaves the port alone.
  assign w_port_free  = !wb_we;
  assign w_copy_start = (r_state == rv32i_types::S_DRAIN) && pipe_empty && !wb_we;
  assign w_sw_we      = r_sv_valid &&
                        ((r_state == rv32i_types::S_COPY) || (r_state == rv32i_types::S_FLUSH));

  swap_write_arbiter u_arb (
    .i_wb_we    (wb_we),
    .i_wb_rd_s  (wb_rd_s),
    .i_wb_rd_v  (wb_rd_v),
    .i_sw_we    (w_sw_we),
    .i_sw_rd_s  (r_sv_idx),
    .i_sw_rd_v  (r_sv),
    .o_we       (regf_we),
    .o_rd_s     (regf_rd_s),
    .o_rd_v     (regf_rd_v),
    .o_sw_grant (w_sw_grant)
  );

  // Swap FSM: drain, stage-and-write copy loop, flush of the last entry, handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= rv32i_types::S_IDLE;
      r_idx       <= 5'd1;
      r_sv        <= 32'd0;
      r_sv_idx    <= 5'd0;
      r_sv_valid  <= 1'b0;
      r_swap_busy <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= 1'b0;
      case (r_state)
        rv32i_types::S_IDLE: begin
          if (swap_req) begin
            r_state     <= rv32i_types::S_DRAIN;
            r_swap_busy <= 1'b1;
          end
        end
        rv32i_types::S_DRAIN: begin
          if (w_copy_start) begin
            r_state    <= rv32i_types::S_COPY;
            r_idx      <= 5'd1;
            r_sv_valid <= 1'b0;
          end
        end
        rv32i_types::S_COPY: begin
          // Capture the next register while the previous one is written out.
          if (w_port_free) begin
            r_sv       <= w_lookup;
            r_sv_idx   <= r_idx;
            r_sv_valid <= 1'b1;
            r_idx      <= r_idx + 5'd1;
            if (r_idx == 5'd31) begin
              r_state <= rv32i_types::S_FLUSH;
            end
          end
        end
        rv32i_types::S_FLUSH: begin
          // x31 leaves the stage register here; wait if writeback holds the port.
          if (w_port_free) begin
            r_sv_valid  <= 1'b0;
            r_idx       <= 5'd1;
            r_state     <= rv32i_types::S_DONE;
            r_swap_done <= 1'b1;
          end
        end
        rv32i_types::S_DONE: begin
          r_state     <= rv32i_types::S_HOLD;
          r_swap_busy <= 1'b0;
        end
        rv32i_types::S_HOLD: begin
          if (!swap_req) begin
            r_state <= rv32i_types::S_IDLE;
          end
        end
        default: begin
          r_state     <= rv32i_types::S_IDLE;
          r_swap_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef SWAP_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running XOR of swap values actually written; cleared when copying begins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_checksum <= 32'd0;
    end else if (w_copy_start) begin
      r_checksum <= 32'd0;
    end else if (w_sw_grant) begin
      r_checksum <= r_checksum ^ r_sv;
    end
  end

  assign swap_checksum = r_checksum;
`endif

  assign swap_busy = r_swap_busy;
  assign swap_done = r_swap_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_swap_sequencer.sv
// Bench for regfile_swap_sequencer. Reference model: a swap is the ordered
// list of writes x1..x31 with data ooo_data[map[r]]; the first port-free COPY
// cycle writes nothing, each later port-free cycle writes the next entry,
// and any writeback cycle passes writeback through instead.
// Build with +define+SWAP_CHECKSUM_EN to cover the checksum output.
`timescale 1ns/1ps
module tb_regfile_swap_sequencer;
  import rv32i_types::*;

  localparam int NR = 64;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          swap_req;
  logic          pipe_empty;
  logic [PW-1:0] rrf_arch_to_physical [32];
  logic [31:0]   ooo_data [NR];
  logic          wb_we;
  logic [4:0]    wb_rd_s;
  logic [31:0]   wb_rd_v;
  logic          regf_we;
  logic [4:0]    regf_rd_s;
  logic [31:0]   regf_rd_v;
  logic          swap_busy;
  logic          swap_done;
  logic [31:0]   swap_checksum;
  swap_state_t   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  // Clock and reset
  always #5 clk = ~clk;

  regfile_swap_sequencer #(.NUM_REGS(NR)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .swap_req             (swap_req),
    .pipe_empty           (pipe_empty),
    .rrf_arch_to_physical (rrf_arch_to_physical),
    .ooo_data             (ooo_data),
    .wb_we                (wb_we),
    .wb_rd_s              (wb_rd_s),
    .wb_rd_v              (wb_rd_v),
    .regf_we              (regf_we),
    .regf_rd_s            (regf_rd_s),
    .regf_rd_v            (regf_rd_v),
    .swap_busy            (swap_busy),
    .swap_done            (swap_done),
`ifdef SWAP_CHECKSUM_EN
    .swap_checksum        (swap_checksum),
`endif
    .dbg_state            (dbg_state)
  );

`ifndef SWAP_CHECKSUM_EN
  assign swap_checksum = 32'd0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver + scoreboard for one complete swap.
  // mode: 0 identity map, data i*0x100; 1 permuted with x5->p40=DEADBEEF;
  //       2 random permutation and data; 3 identity map, data i.
  task automatic run_swap(input int mode, input int drain_cycles, input int pend_wb_at,
                          input int collide_at, input int collide_pct, input int drop_at,
                          input int hold_cycles);
    int perm[NR];
    logic [31:0] exp_sum;
    logic [36:0] e;
    logic [31:0] sum_done;
    logic [4:0]  rd;
    logic [31:0] v;
    bit wbe, first_free, done_next, finished;
    int coll, cyc;
    for (int i = 0; i < NR; i++) perm[i] = i;
    for (int i = NR - 1; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    if (mode == 1) begin
      for (int j = 0; j < NR; j++) begin
        if (perm[j] == 40) begin
          perm[j] = perm[5];
          perm[5] = 40;
          break;
        end
      end
    end
    for (int i = 0; i < NR; i++) ooo_data[i] = $urandom();
    for (int r = 0; r < 32; r++) begin
      rrf_arch_to_physical[r] = (mode == 0 || mode == 3) ? PW'(r) : PW'(perm[r]);
      if (mode == 0) ooo_data[r] = 32'(r) * 32'h100;
      if (mode == 3) ooo_data[r] = 32'(r);
    end
    if (mode == 1) ooo_data[40] = 32'hDEADBEEF;
    exp_q.delete();
    exp_sum = 32'd0;
    for (int r = 1; r < 32; r++) begin
      exp_q.push_back({5'(r), ooo_data[rrf_arch_to_physical[r]]});
      exp_sum ^= ooo_data[rrf_arch_to_physical[r]];
    end

    // request cycle, still IDLE
    swap_req = 1'b1; pipe_empty = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (swap_busy !== 1'b0) begin
      n_err++; $display("FAIL req_busy: got %0b want 0", swap_busy);
    end
    step();

    // drain: writeback keeps flowing, no exit while wb_we is high
    for (int d = 0; d < drain_cycles; d++) begin
      pipe_empty = 1'b0;
      wbe = (d == pend_wb_at) ? 1'b1 : 1'($urandom_range(0, 1));
      rd = (d == pend_wb_at) ? 5'd7 : 5'($urandom_range(0, 31));
      v  = (d == pend_wb_at) ? 32'h55 : $urandom();
      if (mode == 2 && $urandom_range(0, 1) == 1) begin
        pipe_empty = 1'b1; wbe = 1'b1; rd = 5'($urandom_range(1, 31));
      end
      wb_we = wbe; wb_rd_s = rd; wb_rd_v = v;
      @(negedge clk);
      n_cmp++;
      if (swap_busy !== 1'b1 || swap_done !== 1'b0) begin
        n_err++; $display("FAIL drain_flags: busy=%0b done=%0b want 1/0", swap_busy, swap_done);
      end
      n_cmp++;
      if (regf_we !== (wbe && rd != 0) || (wbe && rd != 0 && (regf_rd_s !== rd || regf_rd_v !== v))) begin
        n_err++; $display("FAIL drain_wb: we=%0b x%0d=%h want we=%0b x%0d=%h",
                          regf_we, regf_rd_s, regf_rd_v, wbe && rd != 0, rd, v);
      end
      step();
    end

    // drain exit cycle
    pipe_empty = 1'b1; wb_we = 1'b0; wb_rd_s = 5'($urandom_range(0, 31)); wb_rd_v = $urandom();
    @(negedge clk);
    n_cmp++;
    if (swap_busy !== 1'b1 || regf_we !== 1'b0) begin
      n_err++; $display("FAIL drain_exit: busy=%0b we=%0b want 1/0", swap_busy, regf_we);
    end
    step();

    // copy / flush / done
    first_free = 1'b1; done_next = 1'b0; finished = 1'b0; coll = 0; sum_done = 32'd0;
    for (cyc = 1; cyc <= 150 && !finished; cyc++) begin
      wbe = (cyc == collide_at) || ($urandom_range(0, 99) < collide_pct);
      rd  = (cyc == collide_at) ? 5'd3 : 5'($urandom_range(0, 31));
      v   = (cyc == collide_at) ? 32'hAA : $urandom();
      wb_we = wbe; wb_rd_s = rd; wb_rd_v = v;
      pipe_empty = 1'($urandom_range(0, 1));
      if (cyc == drop_at) swap_req = 1'b0;
      @(negedge clk);
      if (done_next) begin
        finished = 1'b1;
        n_cmp++;
        if (swap_done !== 1'b1 || swap_busy !== 1'b1) begin
          n_err++; $display("FAIL done_pulse: done=%0b busy=%0b want 1/1", swap_done, swap_busy);
        end
        n_cmp++;
        if (cyc != 33 + coll) begin
          n_err++; $display("FAIL latency: done at cycle %0d want %0d", cyc, 33 + coll);
        end
`ifdef SWAP_CHECKSUM_EN
        n_cmp++;
        if (swap_checksum !== exp_sum) begin
          n_err++; $display("FAIL checksum_done: got %h want %h", swap_checksum, exp_sum);
        end
`endif
        sum_done = swap_checksum;
      end else begin
        n_cmp++;
        if (swap_done !== 1'b0 || swap_busy !== 1'b1) begin
          n_err++; $display("FAIL copy_flags c%0d: done=%0b busy=%0b want 0/1", cyc, swap_done, swap_busy);
        end
        if (wbe) begin
          coll++;
          n_cmp++;
          if (regf_we !== (rd != 0) || (rd != 0 && (regf_rd_s !== rd || regf_rd_v !== v))) begin
            n_err++; $display("FAIL copy_wb c%0d: we=%0b x%0d=%h want we=%0b x%0d=%h",
                              cyc, regf_we, regf_rd_s, regf_rd_v, rd != 0, rd, v);
          end
        end else if (first_free) begin
          first_free = 1'b0;
          n_cmp++;
          if (regf_we !== 1'b0) begin
            n_err++; $display("FAIL copy_first: we=%0b x%0d want no write", regf_we, regf_rd_s);
          end
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (regf_we !== 1'b1 || regf_rd_s !== e[36:32] || regf_rd_v !== e[31:0]) begin
            n_err++; $display("FAIL copy_write c%0d: we=%0b x%0d=%h want x%0d=%h",
                              cyc, regf_we, regf_rd_s, regf_rd_v, e[36:32], e[31:0]);
          end
          if (exp_q.size() == 0) done_next = 1'b1;
        end
      end
      step();
    end
    if (!finished) begin
      n_cmp++; n_err++;
      $display("FAIL swap_timeout: no swap_done within 150 cycles (%0d writes left)", exp_q.size());
    end

    // hold: level request must not start a new swap
    wb_we = 1'b0; pipe_empty = 1'b1;
    for (int h = 0; h < hold_cycles && swap_req; h++) begin
      @(negedge clk);
      n_cmp++;
      if (swap_busy !== 1'b0 || swap_done !== 1'b0 || regf_we !== 1'b0 || dbg_state !== S_HOLD) begin
        n_err++; $display("FAIL hold: busy=%0b done=%0b we=%0b state=%0d want 0/0/0/%0d",
                          swap_busy, swap_done, regf_we, dbg_state, S_HOLD);
      end
`ifdef SWAP_CHECKSUM_EN
      n_cmp++;
      if (swap_checksum !== sum_done) begin
        n_err++; $display("FAIL checksum_hold: got %h want %h", swap_checksum, sum_done);
      end
`endif
      step();
    end
    swap_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== S_HOLD || swap_busy !== 1'b0) begin
      n_err++; $display("FAIL hold_last: state=%0d busy=%0b want %0d/0", dbg_state, swap_busy, S_HOLD);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== S_IDLE || swap_busy !== 1'b0) begin
      n_err++; $display("FAIL back_idle: state=%0d busy=%0b want %0d/0", dbg_state, swap_busy, S_IDLE);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; swap_req = 1'b0; pipe_empty = 1'b0;
    wb_we = 1'b0; wb_rd_s = 5'd0; wb_rd_v = 32'd0;
    for (int i = 0; i < 32; i++) rrf_arch_to_physical[i] = PW'(i);
    for (int i = 0; i < NR; i++) ooo_data[i] = 32'd0;
    step(); step();
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== S_IDLE || swap_busy !== 1'b0 || swap_done !== 1'b0) begin
      n_err++; $display("FAIL reset_fsm: state=%0d busy=%0b done=%0b want %0d/0/0",
                        dbg_state, swap_busy, swap_done, S_IDLE);
    end
    n_cmp++;
    if (regf_we !== 1'b0 || regf_rd_s !== 5'd0 || regf_rd_v !== 32'd0 || swap_checksum !== 32'd0) begin
      n_err++; $display("FAIL reset_port: we=%0b s=%0d v=%h sum=%h want all 0",
                        regf_we, regf_rd_s, regf_rd_v, swap_checksum);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_x0_passthrough();
    wb_we = 1'b1; wb_rd_s = 5'd0; wb_rd_v = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if (regf_we !== 1'b0) begin
      n_err++; $display("FAIL x0_suppress: we=%0b want 0", regf_we);
    end
    step();
    wb_rd_s = 5'd9; wb_rd_v = 32'hCAFE_0009;
    @(negedge clk);
    n_cmp++;
    if (regf_we !== 1'b1 || regf_rd_s !== 5'd9 || regf_rd_v !== 32'hCAFE_0009) begin
      n_err++; $display("FAIL idle_pass: we=%0b x%0d=%h want 1 x9=cafe0009", regf_we, regf_rd_s, regf_rd_v);
    end
    step();
    wb_we = 1'b0;
  endtask

  task automatic test_identity();
    run_swap(0, 0, -1, 0, 0, 0, 0);
  endtask

  task automatic test_permuted();
    run_swap(1, 2, -1, 0, 0, 0, 0);
  endtask

  task automatic test_drain();
    run_swap(0, 4, 1, 0, 0, 0, 0);
  endtask

  task automatic test_collision();
    run_swap(0, 0, -1, 12, 0, 0, 0);
  endtask

  task automatic test_checksum_hold();
    run_swap(3, 1, -1, 0, 0, 0, 5);
`ifdef SWAP_CHECKSUM_EN
    n_cmp++;
    if (swap_checksum !== 32'd0) begin
      n_err++; $display("FAIL checksum_identity: got %h want 0", swap_checksum);
    end
`endif
  endtask

  task automatic test_reset_mid_copy();
    swap_req = 1'b1; pipe_empty = 1'b0; wb_we = 1'b0;
    step();
    pipe_empty = 1'b1;
    step();
    for (int c = 1; c < 10; c++) step();
    @(negedge clk);
    n_cmp++;
    if (regf_we !== 1'b1 || regf_rd_s !== 5'd9) begin
      n_err++; $display("FAIL pre_reset_x9: we=%0b x%0d want 1 x9", regf_we, regf_rd_s);
    end
    rst = 1'b0; swap_req = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== S_IDLE || swap_busy !== 1'b0 || regf_we !== 1'b0 || swap_done !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: state=%0d busy=%0b we=%0b done=%0b want %0d/0/0/0",
                        dbg_state, swap_busy, regf_we, swap_done, S_IDLE);
    end
    step();
    rst = 1'b1;
    step();
    run_swap(0, 0, -1, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_swap(2, $urandom_range(0, 5), -1, 0, 25,
               ($urandom_range(0, 1) == 1) ? $urandom_range(2, 40) : 0, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_x0_passthrough();
    test_identity();
    test_permuted();
    test_drain();
    test_collision();
    test_checksum_hold();
    test_reset_mid_copy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
